// File: rtl/gearbox_arbiter.sv
// Round-robin arbiter feeding four 16-bit requesters into a gearbox write port.
// Each grant pays one idle bubble, then streams zero-latency until last or MAX_BURST.
module gearbox_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        clk_400MHz,
    input  logic        res,
    input  logic [3:0]  req_valid,
    input  logic [3:0]  req_last,
    input  logic [63:0] req_data,
    output logic [3:0]  req_ready,
    input  logic        gb_full,
    output logic        gb_shift_in,
    output logic [15:0] gb_data_in,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state_q;
    logic [1:0]     grant_q;
    logic [1:0]     rr_ptr_q;
    logic [CW-1:0]  burst_cnt_q;

    logic [1:0]     sel_c;
    logic           any_c;
    logic           xfer_c;
    logic           done_c;

    // First valid requester starting at rr_ptr, wrapping modulo 4
    always_comb begin
        logic [1:0] idx;
        logic       found;
        sel_c = rr_ptr_q;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 2'(rr_ptr_q + 2'(k));
            if (!found && req_valid[idx]) begin
                sel_c = idx;
                found = 1'b1;
            end
        end
        any_c = |req_valid;
    end

    // A word offered while res is high is never accepted
    assign xfer_c = (state_q == BURST) && !res && req_valid[grant_q] && !gb_full;
    assign done_c = req_last[grant_q] || (burst_cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        req_ready   = '0;
        gb_shift_in = xfer_c;
        gb_data_in  = '0;
        if (state_q == BURST && !res) begin
            req_ready[grant_q] = !gb_full;
        end
        if (xfer_c) begin
            gb_data_in = req_data[{grant_q, 4'b0000} +: DW];
        end
    end

    assign busy     = (state_q == BURST);
    assign grant_id = grant_q;

    always_ff @(posedge clk_400MHz) begin
        if (res) begin
            state_q     <= IDLE;
            grant_q     <= 2'd0;
            rr_ptr_q    <= 2'd0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_c) begin
                        state_q     <= BURST;
                        grant_q     <= sel_c;
                        burst_cnt_q <= '0;
                    end
                end
                BURST: begin
                    // Grant stays locked to grant_q until a transfer closes the burst
                    if (xfer_c) begin
                        burst_cnt_q <= CW'(burst_cnt_q + 1'b1);
                        if (done_c) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= 2'(grant_q + 2'd1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gearbox_arbiter.sv
// Scoreboard bench for gearbox_arbiter: per-requester word queues drive the DUT,
// hand-ordered expected transfers are popped by a monitor on every gb_shift_in.
module tb_gearbox_arbiter;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } word_t;

    typedef struct packed {
        logic [1:0]  g;
        logic [15:0] d;
    } exp_t;

    logic        clk_400MHz;
    logic        res;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        gb_full;
    logic        gb_shift_in;
    logic [15:0] gb_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    word_t rq [4][$];
    exp_t  exp_q [$];
    logic [3:0] pause;
    int n_checks = 0;
    int n_pass   = 0;

    gearbox_arbiter #(.MAX_BURST(8)) dut (
        .clk_400MHz (clk_400MHz),
        .res        (res),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .gb_full    (gb_full),
        .gb_shift_in(gb_shift_in),
        .gb_data_in (gb_data_in),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial begin
        clk_400MHz = 1'b0;
        forever #5 clk_400MHz = ~clk_400MHz;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every write strobe must match the next expected transfer
    always @(negedge clk_400MHz) begin
        if (gb_shift_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_shift: got data 0x%0h grant %0d with nothing expected at %0t",
                         gb_data_in, grant_id, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("xfer_data", 32'(gb_data_in), 32'(e.d));
                check("xfer_grant", 32'(grant_id), 32'(e.g));
                check("xfer_while_full", 32'(gb_full), 32'd0);
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]         = !pause[i];
                req_data[16*i +: 16] = rq[i][0].d;
                req_last[i]          = rq[i][0].l;
            end else begin
                req_valid[i]         = 1'b0;
                req_data[16*i +: 16] = 16'h0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [3:0] hs;
        word_t w;
        @(negedge clk_400MHz);
        hs = req_valid & req_ready;
        @(posedge clk_400MHz);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) w = rq[i].pop_front();
        end
        drive();
    endtask

    task automatic push(input int r, input logic [15:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        rq[r].push_back(w);
    endtask

    task automatic expect_x(input logic [1:0] g, input logic [15:0] d);
        exp_t e;
        e.g = g;
        e.d = d;
        exp_q.push_back(e);
    endtask

    function automatic bit pending();
        return exp_q.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 ||
               rq[2].size() != 0 || rq[3].size() != 0;
    endfunction

    // Run until all words are moved; the cycle count pins down bubbles and releases
    task automatic drain(input string name, input int exp_cycles);
        int n;
        n = 0;
        while (pending() && n < exp_cycles + 20) begin
            cycle();
            n++;
        end
        check(name, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        res       = 1'b1;
        gb_full   = 1'b0;
        pause     = 4'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        drive();
        cycle();
        cycle();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_shift", 32'(gb_shift_in), 32'd0);
        check("rst_data", 32'(gb_data_in), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        res = 1'b0;
        drive();

        // Single requester, three words, one bubble
        push(0, 16'hA001, 1'b0);
        push(0, 16'hB002, 1'b0);
        push(0, 16'hC003, 1'b1);
        expect_x(2'd0, 16'hA001);
        expect_x(2'd0, 16'hB002);
        expect_x(2'd0, 16'hC003);
        drive();
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
        drain("single_cycles", 4);
        #1;
        check("single_end_busy", 32'(busy), 32'd0);

        // rr_ptr=1 after serving req0: req1 wins over req0
        push(0, 16'h1100, 1'b1);
        push(1, 16'h1110, 1'b1);
        expect_x(2'd1, 16'h1110);
        expect_x(2'd0, 16'h1100);
        drive();
        drain("rr_probe_cycles", 4);

        // Round-robin from reset: 0,1,2,3,0
        res = 1'b1;
        drive();
        cycle();
        res = 1'b0;
        push(0, 16'h2000, 1'b1);
        push(0, 16'h2001, 1'b1);
        push(1, 16'h2100, 1'b1);
        push(2, 16'h2200, 1'b1);
        push(3, 16'h2300, 1'b1);
        expect_x(2'd0, 16'h2000);
        expect_x(2'd1, 16'h2100);
        expect_x(2'd2, 16'h2200);
        expect_x(2'd3, 16'h2300);
        expect_x(2'd0, 16'h2001);
        drive();
        drain("rr_cycles", 10);

        // Burst limit: 8 words, release, regrant req2 for the remaining 4
        for (int k = 0; k < 12; k++) begin
            push(2, 16'(16'h3000 + k), k == 11);
            expect_x(2'd2, 16'(16'h3000 + k));
        end
        drive();
        drain("limit_cycles", 14);

        // Back-pressure: 5-cycle stall after two words, count must freeze
        for (int k = 0; k < 10; k++) begin
            push(3, 16'(16'h4000 + k), k == 9);
            expect_x(2'd3, 16'(16'h4000 + k));
        end
        drive();
        cycle();
        cycle();
        cycle();
        gb_full = 1'b1;
        drive();
        #1;
        for (int s = 0; s < 5; s++) begin
            check("stall_shift", 32'(gb_shift_in), 32'd0);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            cycle();
            if (s == 4) gb_full = 1'b0;
            drive();
            #1;
        end
        drain("stall_resume_cycles", 9);

        // Lock: req0 drops valid for 3 cycles, req2/req3 must wait
        for (int k = 0; k < 4; k++) begin
            push(0, 16'(16'h5000 + k), k == 3);
            expect_x(2'd0, 16'(16'h5000 + k));
        end
        push(2, 16'h5200, 1'b1);
        push(3, 16'h5300, 1'b1);
        expect_x(2'd2, 16'h5200);
        expect_x(2'd3, 16'h5300);
        drive();
        cycle();
        cycle();
        cycle();
        pause[0] = 1'b1;
        drive();
        #1;
        for (int s = 0; s < 3; s++) begin
            check("lock_other_ready", 32'(req_ready & 4'b1110), 32'd0);
            check("lock_shift", 32'(gb_shift_in), 32'd0);
            check("lock_grant", 32'(grant_id), 32'd0);
            cycle();
            #1;
        end
        pause[0] = 1'b0;
        drive();
        drain("lock_cycles", 6);

        // Reset mid-burst after the 2nd of 4 words
        for (int k = 0; k < 4; k++) begin
            push(1, 16'(16'h6000 + k), k == 3);
        end
        expect_x(2'd1, 16'h6000);
        expect_x(2'd1, 16'h6001);
        drive();
        cycle();
        cycle();
        cycle();
        res = 1'b1;
        drive();
        #1;
        check("rst_cycle_shift", 32'(gb_shift_in), 32'd0);
        check("rst_cycle_ready", 32'(req_ready), 32'd0);
        cycle();
        res = 1'b0;
        push(0, 16'h6100, 1'b1);
        expect_x(2'd0, 16'h6100);
        expect_x(2'd1, 16'h6002);
        expect_x(2'd1, 16'h6003);
        drive();
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        check("rst_mid_grant", 32'(grant_id), 32'd0);
        drain("rst_mid_cycles", 5);

        // last on the 8th word: a single release, then req3
        for (int k = 0; k < 8; k++) begin
            push(2, 16'(16'h7000 + k), k == 7);
            expect_x(2'd2, 16'(16'h7000 + k));
        end
        push(3, 16'h7300, 1'b1);
        expect_x(2'd3, 16'h7300);
        drive();
        drain("coincide_cycles", 11);

        cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gearbox_arbiter.md
GEARBOX_ARBITER -- requirements
Module: gearbox_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 8, meaning the maximum words per grant (legal range 1..255).
REQ-002 The block SHALL have port clk_400MHz, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port res, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 4 bits: requester i has a 16-bit word offered.
REQ-005 The block SHALL have port req_last, input, 4 bits: requester i's offered word ends its burst.
REQ-006 The block SHALL have port req_data, input, 64 bits: requester i's word at [16i+15:16i].
REQ-007 The block SHALL have port req_ready, output, 4 bits: requester i's word is accepted this cycle when its valid and ready are both high.
REQ-008 The block SHALL have port gb_full, input, 1 bit: gearbox write side full; no write allowed.
REQ-009 The block SHALL have port gb_shift_in, output, 1 bit: write strobe to the gearbox.
REQ-010 The block SHALL have port gb_data_in, output, 16 bits: write data to the gearbox.
REQ-011 The block SHALL have port grant_id, output, 2 bits: index of the currently granted requester.
REQ-012 The block SHALL have port busy, output, 1 bit: a burst grant is active.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and BURST, with the state, grant_id, rr_ptr (2 bits) and burst_cnt (8 bits) all registered.
REQ-014 In IDLE with any req_valid high, the block SHALL select the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo 4; on the next edge it SHALL enter BURST with grant_id=i and burst_cnt=0.
REQ-015 In IDLE, req_ready SHALL be 0, gb_shift_in 0, gb_data_in 0 and busy 0, so arbitration costs exactly one bubble cycle per burst.
REQ-016 In BURST, req_ready[grant_id] SHALL equal !gb_full, combinationally, and all other req_ready bits SHALL be 0.
REQ-017 A transfer SHALL occur in a cycle when BURST && req_valid[grant_id] && !gb_full.
REQ-018 During a transfer, gb_shift_in SHALL be 1 and gb_data_in SHALL equal requester grant_id's word in the same cycle (zero latency, combinational path).
REQ-019 In BURST without a transfer, gb_shift_in SHALL be 0 and gb_data_in SHALL be 0.
REQ-020 On a transfer, burst_cnt SHALL increment by 1.
REQ-021 On a transfer with req_last[grant_id]=1, or with burst_cnt=MAX_BURST-1, the block SHALL return to IDLE on the next edge and set rr_ptr=grant_id+1 mod 4 (wrap 3->0).
REQ-022 gb_full high SHALL stall the burst with no transfer, and burst_cnt and grant SHALL hold; gb_full falling SHALL resume transfers in that same cycle.
REQ-023 If the granted requester drops req_valid mid-burst, the grant SHALL be held (lock) until its burst terminates per REQ-021; other requesters SHALL NOT be served meanwhile.
REQ-024 req_last on a word not transferred (because of gb_full or invalid) SHALL have no effect.
REQ-025 When req_last and the MAX_BURST limit coincide, the block SHALL perform a single release with rr_ptr updated once.
REQ-026 With MAX_BURST=1, every grant SHALL carry exactly one word.
REQ-027 grant_id SHALL hold its last value while in IDLE.
REQ-028 busy SHALL be 1 exactly while in BURST.

Reset
REQ-029 With res high at a rising edge, the block SHALL enter IDLE with rr_ptr=0, grant_id=0 and burst_cnt=0, regardless of state, including mid-burst.
REQ-030 From the cycle after that edge until the next grant, req_ready, gb_shift_in, gb_data_in and busy SHALL all be 0.
REQ-031 A word offered during the reset cycle SHALL NOT be transferred.
REQ-032 The first grant after reset release SHALL occur no earlier than one cycle after res falls.

Verification
REQ-033 Single requester: req0 offers 3 words A,B,C with last on C, gb_full=0 -> one idle cycle, then gb_shift_in high for 3 consecutive cycles with data A,B,C, then IDLE, and rr_ptr=1.
REQ-034 Round-robin: all 4 requesters continuously valid with last on every word -> grant order 0,1,2,3,0; each grant is one transfer followed by one idle cycle.
REQ-035 Burst limit: MAX_BURST=8, req2 streams 12 words with no last -> 8 transfers, release, rr_ptr=3, then req2 regranted (as sole requester) for the remaining 4 words.
REQ-036 Back-pressure: gb_full held high for 5 cycles mid-burst -> no gb_shift_in during those cycles, req_ready[g]=0, burst_cnt frozen, data order preserved after gb_full falls.
REQ-037 Reset mid-burst: res asserted after the 2nd of 4 words -> next cycle IDLE, busy=0, rr_ptr=0; after release req0 is served first if valid.
REQ-038 Lock: the granted requester drops valid for 3 cycles while others are valid -> no other requester receives req_ready; the burst resumes and completes on last.
